// File: rtl/l2_cacheline_adaptor_if.sv
// l2_cacheline_adaptor_if
//
// Purpose: bundles the two buses that meet at the L2 cache-line adaptor.
//   - L2 side: line-granularity physical-memory port (address_i, line_i,
//     line_o, read_i, write_i, resp_o).
//   - Memory side: 64-bit burst port (address_o, burst_i, burst_o, read_o,
//     write_o, resp_i).
//
// Modports:
//   slave  - the adaptor's view. It consumes the L2 request and the memory
//            beats, and produces the line, the burst commands and resp_o.
//   master - the environment's view (L2 controller plus main memory).
//            Every direction is the mirror image of slave.

interface l2_cacheline_adaptor_if;

    // L2 cache side
    logic [31:0]  address_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         read_i;
    logic         write_i;
    logic         resp_o;

    // Main-memory burst side
    logic [31:0]  address_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    modport slave (
        input  address_i,
        input  line_i,
        input  read_i,
        input  write_i,
        input  burst_i,
        input  resp_i,
        output line_o,
        output resp_o,
        output address_o,
        output burst_o,
        output read_o,
        output write_o
    );

    modport master (
        output address_i,
        output line_i,
        output read_i,
        output write_i,
        output burst_i,
        output resp_i,
        input  line_o,
        input  resp_o,
        input  address_o,
        input  burst_o,
        input  read_o,
        input  write_o
    );

endinterface

// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor
//
// Purpose: turns a 256-bit L2 line read or write into a 4-beat, 64-bit
// burst on main memory, then gives L2 a one-cycle completion pulse.
// Beat k carries line bits [64k+63:64k], so beat 0 is the low quarter.
//
// Ports:
//   clk - sole clock. All state updates on its rising edge.
//   rst - asynchronous, active-low reset. The adaptor returns to IDLE with
//         every register cleared, and any burst in progress is abandoned
//         without a response.
//   bus - l2_cacheline_adaptor_if.slave:
//         address_i/line_i/read_i/write_i in, line_o/resp_o out (L2 side)
//         burst_i/resp_i in, address_o/burst_o/read_o/write_o out (memory side)

module l2_cacheline_adaptor (
    input  logic                      clk,
    input  logic                      rst,
    l2_cacheline_adaptor_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_BURST  = 2'd1,
        WRITE_BURST = 2'd2,
        DONE        = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] wline_q, wline_d;
    logic [255:0] rline_q, rline_d;
    logic [1:0]   beat_q, beat_d;
    logic         started_q, started_d;

    // Bit offset of the current beat within a line. beat_q * 64 is a
    // concatenation with six zeros.
    logic [7:0]   beat_base;
    assign beat_base = {beat_q, 6'd0};

    // State and datapath registers. They are cleared asynchronously so a
    // reset in the middle of a burst takes effect at once, with no clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            wline_q   <= 256'd0;
            rline_q   <= 256'd0;
            beat_q    <= 2'd0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wline_q   <= wline_d;
            rline_q   <= rline_d;
            beat_q    <= beat_d;
            started_q <= started_d;
        end
    end

    // Next-state and datapath update.
    // The L2 request is sampled only in IDLE, so any change to
    // address_i/line_i during a burst has no effect. A write wins when
    // read_i and write_i are both high. In the burst states, each cycle with
    // resp_i high moves one beat. The 2-bit beat counter wraps naturally from
    // 3 to 0 on the last beat. started_q records that the memory has accepted
    // the command, so the command is not re-issued across gaps in resp_i.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wline_d   = wline_q;
        rline_d   = rline_q;
        beat_d    = beat_q;
        started_d = started_q;

        unique case (state_q)
            IDLE: begin
                if (bus.write_i) begin
                    addr_d    = bus.address_i;
                    wline_d   = bus.line_i;
                    beat_d    = 2'd0;
                    started_d = 1'b0;
                    state_d   = WRITE_BURST;
                end else if (bus.read_i) begin
                    addr_d    = bus.address_i;
                    beat_d    = 2'd0;
                    started_d = 1'b0;
                    state_d   = READ_BURST;
                end
            end

            READ_BURST: begin
                if (bus.resp_i) begin
                    rline_d[beat_base +: 64] = bus.burst_i;
                    beat_d    = beat_q + 2'd1;
                    started_d = 1'b1;
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end

            WRITE_BURST: begin
                if (bus.resp_i) begin
                    beat_d    = beat_q + 2'd1;
                    started_d = 1'b1;
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state only. No input reaches an
    // output combinationally.
    // The commands are held only until the first beat is accepted.
    // address_o clears the five offset bits by masking, so the whole
    // latched address is read.
    // burst_o always shows the current beat of the latched write line. It is
    // meaningful only during WRITE_BURST.
    always_comb begin
        bus.read_o    = 1'b0;
        bus.write_o   = 1'b0;
        bus.resp_o    = 1'b0;

        unique case (state_q)
            READ_BURST:  bus.read_o  = !started_q;
            WRITE_BURST: bus.write_o = !started_q;
            DONE:        bus.resp_o  = 1'b1;
            default:     ;
        endcase
    end

    assign bus.address_o = addr_q & 32'hFFFF_FFE0;
    assign bus.burst_o   = wline_q[beat_base +: 64];
    assign bus.line_o    = rline_q;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb_l2_cacheline_adaptor
//
// Purpose: directed, self-checking bench for l2_cacheline_adaptor. Inputs
// are driven 2 ns after each rising edge and outputs are checked in the
// same window, well away from the edge. All expected values are literal
// constants written into the stimulus.

module tb_l2_cacheline_adaptor;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks_total  = 0;
    int checks_passed = 0;

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    l2_cacheline_adaptor_if bus ();

    l2_cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drive every adaptor input in one call. The L2 request and the memory
    // beat/strobe are set together.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr,
                                 input logic [255:0] line,
                                 input logic strobe,
                                 input logic [63:0] beat);
        bus.read_i    = rd;
        bus.write_i   = wr;
        bus.address_i = addr;
        bus.line_i    = line;
        bus.resp_i    = strobe;
        bus.burst_i   = beat;
    endtask

    // One comparison. It counts, asserts, and reports on failure.
    task automatic checkOutput(input string tag,
                               input logic [255:0] observed,
                               input logic [255:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Advance to 2 ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Safety net in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        logic [255:0] wb_line;
        logic [255:0] both_line;
        logic [63:0]  gap_beats [4];
        logic         gap_pattern [7];
        int           k;

        gap_beats   = '{64'hA, 64'hB, 64'hC, 64'hD};
        gap_pattern = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        wb_line     = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                       64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
        both_line   = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
                       64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};

        // Reset state, checked while reset is held.
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 64'h0);
        #3;
        checkOutput("rst_resp_o",    bus.resp_o,    0);
        checkOutput("rst_read_o",    bus.read_o,    0);
        checkOutput("rst_write_o",   bus.write_o,   0);
        checkOutput("rst_line_o",    bus.line_o,    0);
        checkOutput("rst_address_o", bus.address_o, 0);
        checkOutput("rst_burst_o",   bus.burst_o,   0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        step();

        // Read with no gaps. The low five address bits must be cleared, the
        // command is high for cycle 1 only, and resp_o arrives in cycle 5.
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, 256'h0, 1'b0, 64'h0);
        step();
        checkOutput("rd_read_o_c1",  bus.read_o,    1);
        checkOutput("rd_address_o",  bus.address_o, 32'h0000_1220);
        checkOutput("rd_resp_o_c1",  bus.resp_o,    0);
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, 256'h0, 1'b1, 64'h1111_1111_1111_1111);
        step();
        checkOutput("rd_read_o_c2",  bus.read_o,    0);
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, 256'h0, 1'b1, 64'h2222_2222_2222_2222);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, 256'h0, 1'b1, 64'h3333_3333_3333_3333);
        step();
        checkOutput("rd_resp_o_c4",  bus.resp_o,    0);
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, 256'h0, 1'b1, 64'h4444_4444_4444_4444);
        step();
        checkOutput("rd_resp_o_c5",  bus.resp_o,    1);
        checkOutput("rd_line_o",     bus.line_o,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 64'h0);
        step();
        checkOutput("rd_resp_o_c6",  bus.resp_o,    0);

        // Write with gaps in resp_i. write_o is high until the first strobe,
        // burst_o shows A, B, C, D on the strobes, and resp_o comes one
        // cycle after the fourth strobe.
        applyStimulus(1'b0, 1'b1, 32'h0000_0400, {64'hD, 64'hC, 64'hB, 64'hA}, 1'b0, 64'h0);
        step();
        k = 0;
        for (int i = 0; i < 7; i++) begin
            checkOutput("wg_write_o", bus.write_o, (k == 0) ? 1 : 0);
            checkOutput("wg_resp_o",  bus.resp_o,  0);
            if (gap_pattern[i]) begin
                checkOutput("wg_burst_o", bus.burst_o, gap_beats[k]);
                k++;
            end
            applyStimulus(1'b0, 1'b1, 32'h0000_0400, {64'hD, 64'hC, 64'hB, 64'hA},
                          gap_pattern[i], 64'h0);
            step();
        end
        checkOutput("wg_resp_o_end", bus.resp_o, 1);
        checkOutput("wg_line_o_kept", bus.line_o,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 64'h0);
        step();

        // Write-back to 0x100 followed by a refill from 0x200, with exactly
        // one idle cycle between the two bursts. line_o must hold its value
        // during the write.
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, wb_line, 1'b0, 64'h0);
        step();
        checkOutput("wb_write_o",   bus.write_o,   1);
        checkOutput("wb_address_o", bus.address_o, 32'h0000_0100);
        for (int b = 0; b < 4; b++) begin
            checkOutput("wb_burst_o", bus.burst_o, wb_line[64*b +: 64]);
            checkOutput("wb_line_o_kept", bus.line_o,
                        {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
            applyStimulus(1'b0, 1'b1, 32'h0000_0100, wb_line, 1'b1, 64'h0);
            step();
        end
        checkOutput("wb_resp_o", bus.resp_o, 1);
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 64'h0);
        step();
        checkOutput("gap_idle_read_o",  bus.read_o,  0);
        checkOutput("gap_idle_write_o", bus.write_o, 0);
        checkOutput("gap_idle_resp_o",  bus.resp_o,  0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0200, 256'h0, 1'b0, 64'h0);
        step();
        checkOutput("rf_read_o",    bus.read_o,    1);
        checkOutput("rf_address_o", bus.address_o, 32'h0000_0200);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, 1'b0, 32'h0000_0200, 256'h0, 1'b1,
                          64'h7777_0000_0000_0000 + 64'(b));
            step();
        end
        checkOutput("rf_resp_o", bus.resp_o, 1);
        checkOutput("rf_line_o", bus.line_o,
                    {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                     64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000});
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 64'h0);
        step();

        // read_i and write_i both high: the write has priority.
        applyStimulus(1'b1, 1'b1, 32'h0000_0300, both_line, 1'b0, 64'h0);
        step();
        checkOutput("both_write_o",   bus.write_o,   1);
        checkOutput("both_read_o",    bus.read_o,    0);
        checkOutput("both_address_o", bus.address_o, 32'h0000_0300);
        checkOutput("both_burst_o",   bus.burst_o,   64'h5555_0000_0000_0000);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, 1'b1, 32'h0000_0300, both_line, 1'b1, 64'hFFFF);
            step();
        end
        checkOutput("both_resp_o", bus.resp_o, 1);
        checkOutput("both_line_o_kept", bus.line_o,
                    {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                     64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000});
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 64'h0);
        step();

        // Reset in the middle of a read, after two beats. The outputs clear
        // without a clock edge, no resp_o follows, and the next read lands
        // its first beat in the low 64 bits.
        applyStimulus(1'b1, 1'b0, 32'h0000_0500, 256'h0, 1'b0, 64'h0);
        step();
        checkOutput("rr_read_o_c1", bus.read_o, 1);
        applyStimulus(1'b1, 1'b0, 32'h0000_0500, 256'h0, 1'b1, 64'h9999_0000_0000_0000);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_0500, 256'h0, 1'b1, 64'h9999_0000_0000_0001);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 64'h0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rr_read_o",    bus.read_o,    0);
        checkOutput("rr_line_o",    bus.line_o,    0);
        checkOutput("rr_address_o", bus.address_o, 0);
        checkOutput("rr_burst_o",   bus.burst_o,   0);
        checkOutput("rr_resp_o",    bus.resp_o,    0);
        step();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("rr_no_resp_o", bus.resp_o, 0);
            checkOutput("rr_no_read_o", bus.read_o, 0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0000_0600, 256'h0, 1'b0, 64'h0);
        step();
        checkOutput("rr2_read_o",    bus.read_o,    1);
        checkOutput("rr2_address_o", bus.address_o, 32'h0000_0600);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, 1'b0, 32'h0000_0600, 256'h0, 1'b1,
                          64'hBEEF_0000_0000_0000 + 64'(b));
            step();
        end
        checkOutput("rr2_resp_o", bus.resp_o, 1);
        checkOutput("rr2_line_o", bus.line_o,
                    {64'hBEEF_0000_0000_0003, 64'hBEEF_0000_0000_0002,
                     64'hBEEF_0000_0000_0001, 64'hBEEF_0000_0000_0000});
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 64'h0);
        step();

        // resp_i strobes in IDLE must leave the adaptor idle and untouched.
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("sp_resp_o",    bus.resp_o,    0);
            checkOutput("sp_read_o",    bus.read_o,    0);
            checkOutput("sp_write_o",   bus.write_o,   0);
            checkOutput("sp_address_o", bus.address_o, 32'h0000_0600);
            checkOutput("sp_line_o",    bus.line_o,
                        {64'hBEEF_0000_0000_0003, 64'hBEEF_0000_0000_0002,
                         64'hBEEF_0000_0000_0001, 64'hBEEF_0000_0000_0000});
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 64'h0);
        step();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
